// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the 16-bit multicycle datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select. Outputs are a decode of the
// current state, with mem_ready and zero gating a few strobes combinationally.
//
// state | enc | meaning
// ------+-----+-----------------------------------------------------------
// FETCH |  0  | read IR from mem[PC], PC <= PC+1 when mem_ready
// DECODE|  1  | branch target into ALUOut, dispatch on op
// MEMADR|  2  | effective address regA + sext(imm6)
// MEMRD |  3  | load read, waits on mem_ready
// MEMWB |  4  | load writeback from MDR into rt
// MEMWR |  5  | store write, strobe held until mem_ready
// RTEX  |  6  | R-type ALU op on regA, regB with f = funct
// RTWB  |  7  | R-type writeback into rd
// BEQEX |  8  | compare regA - regB, PC <= ALUOut if zero
// ADDIEX|  9  | regA + sext(imm6)
// ADDIWB| 10  | ADDI writeback into rt
// JEX   | 11  | PC <= {PC[15:12], IR[11:0]}
// HALT  | 12  | parked after an illegal instruction, left only by reset

module multicycle_control_fsm #(
    parameter logic ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] op,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_f,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQEX  = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JEX    = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BOFFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_funct_legal;
    logic       w_illegal_dec;
    logic [3:0] w_illegal_target;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_f;
    logic [1:0] w_pc_src;
    logic       w_illegal;
    logic       w_retire;

    // Classify the instruction held in IR; only meaningful while in DECODE.
    always_comb begin
        w_funct_legal = 1'b0;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: w_funct_legal = 1'b1;
            default:                          w_funct_legal = 1'b0;
        endcase

        w_illegal_dec = 1'b0;
        case (op)
            OP_RTYPE:                         w_illegal_dec = ~w_funct_legal;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_illegal_dec = 1'b0;
            default:                          w_illegal_dec = 1'b1;
        endcase

        w_illegal_target = ILLEGAL_TRAP ? S_HALT : S_FETCH;
    end

    // Next-state selection.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_illegal_dec) begin
                    w_next_state = w_illegal_target;
                end else begin
                    case (op)
                        OP_LW, OP_SW: w_next_state = S_MEMADR;
                        OP_BEQ:       w_next_state = S_BEQEX;
                        OP_ADDI:      w_next_state = S_ADDIEX;
                        OP_J:         w_next_state = S_JEX;
                        default:      w_next_state = S_RTEX;
                    endcase
                end
            end
            // op still holds LW or SW here because IR only loads in FETCH
            S_MEMADR: w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   w_next_state = S_RTWB;
            S_RTWB:   w_next_state = S_FETCH;
            S_BEQEX:  w_next_state = S_FETCH;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: w_next_state = S_FETCH;
            S_JEX:    w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Per-state control word; anything not set stays 0 (HALT relies on this).
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_REGB;
        w_alu_f         = F_AND;
        w_pc_src        = PCSRC_ALU;
        w_illegal       = 1'b0;
        w_retire        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_iord      = 1'b0;
                w_alu_src_a = 1'b0;
                w_alu_src_b = SRCB_ONE;
                w_alu_f     = F_ADD;
                w_pc_src    = PCSRC_ALU;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = 1'b0;
                w_alu_src_b = SRCB_BOFFS;
                w_alu_f     = F_ADD;
                w_illegal   = w_illegal_dec;
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_alu_f     = F_ADD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_dst    = 1'b0;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = mem_ready;
            end
            S_RTEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_REGB;
                w_alu_f     = funct;
            end
            S_RTWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQEX: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = SRCB_REGB;
                w_alu_f         = F_SUB;
                w_pc_src        = PCSRC_ALUOUT;
                w_pc_write_cond = 1'b1;
                w_retire        = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_alu_f     = F_ADD;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b0;
                w_retire    = 1'b1;
            end
            S_JEX: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
            end
            default: begin
                w_alu_f = F_AND;
            end
        endcase
    end

    // Strobes that change architectural state are squashed while reset is
    // asserted so an abandoned instruction never half-commits.
    always_comb begin
        pc_en      = reset_n & (w_pc_write | (w_pc_write_cond & zero));
        ir_write   = reset_n & w_ir_write;
        mem_write  = reset_n & w_mem_write;
        reg_write  = reset_n & w_reg_write;
        illegal    = reset_n & w_illegal;
        retire     = reset_n & w_retire;
        iord       = w_iord;
        reg_dst    = w_reg_dst;
        mem_to_reg = w_mem_to_reg;
        alu_src_a  = w_alu_src_a;
        alu_src_b  = w_alu_src_b;
        alu_f      = w_alu_f;
        pc_src     = w_pc_src;
        state      = r_state;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one instance with illegal
// instructions skipped, one parked in HALT on an illegal instruction.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       reset_t_n;
    logic [3:0] op;
    logic [2:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal, retire;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_f;
    logic [3:0] state;

    logic       t_pc_en, t_iord, t_mem_write, t_ir_write, t_reg_dst, t_mem_to_reg, t_reg_write;
    logic       t_alu_src_a, t_illegal, t_retire;
    logic [1:0] t_alu_src_b, t_pc_src;
    logic [2:0] t_alu_f;
    logic [3:0] t_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_f(alu_f), .pc_src(pc_src), .illegal(illegal), .retire(retire),
        .state(state)
    );

    multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) u_trap (
        .clk(clk), .reset_n(reset_t_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(t_pc_en), .iord(t_iord), .mem_write(t_mem_write),
        .ir_write(t_ir_write), .reg_dst(t_reg_dst), .mem_to_reg(t_mem_to_reg),
        .reg_write(t_reg_write), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
        .alu_f(t_alu_f), .pc_src(t_pc_src), .illegal(t_illegal), .retire(t_retire),
        .state(t_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_t_n = 1'b0;
        op        = 4'd0;
        funct     = 3'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // reset: FETCH, strobes forced low even with mem_ready high
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_trap_state", 32'(t_state), 32'd0);

        // ADD: 0,1,6,7,0
        @(negedge clk); reset_n = 1'b1; reset_t_n = 1'b1; op = 4'b0000; funct = 3'b010; #1;
        chk("add_fetch_state", 32'(state), 32'd0);
        chk("add_fetch_ctl", 32'({ir_write, pc_en, iord, alu_src_a, alu_src_b, alu_f, pc_src}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00}));
        @(negedge clk); #1;
        chk("add_decode_state", 32'(state), 32'd1);
        chk("add_decode_ctl", 32'({alu_src_a, alu_src_b, alu_f, illegal, ir_write}),
            32'({1'b0, 2'b11, 3'b010, 1'b0, 1'b0}));
        @(negedge clk); #1;
        chk("add_rtex_state", 32'(state), 32'd6);
        chk("add_rtex_ctl", 32'({alu_src_a, alu_src_b, alu_f, reg_write, retire}),
            32'({1'b1, 2'b00, 3'b010, 1'b0, 1'b0}));
        @(negedge clk); #1;
        chk("add_rtwb_state", 32'(state), 32'd7);
        chk("add_rtwb_ctl", 32'({reg_write, reg_dst, mem_to_reg, retire}), 32'b1101);
        @(negedge clk); #1;
        chk("add_end_state", 32'(state), 32'd0);
        chk("add_end_retire", 32'(retire), 32'd0);

        // LW with mem_ready low three cycles in MEMRD
        op = 4'b0001;
        @(negedge clk); #1;
        chk("lw_decode_state", 32'(state), 32'd1);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("lw_memadr_state", 32'(state), 32'd2);
        chk("lw_memadr_ctl", 32'({alu_src_a, alu_src_b, alu_f}), 32'({1'b1, 2'b10, 3'b010}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("lw_wait_state", 32'(state), 32'd3);
            chk("lw_wait_ctl", 32'({iord, reg_write, retire}), 32'b100);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("lw_memrd_ready_state", 32'(state), 32'd3);
        @(negedge clk); #1;
        chk("lw_memwb_state", 32'(state), 32'd4);
        chk("lw_memwb_ctl", 32'({reg_write, mem_to_reg, reg_dst, retire}), 32'b1101);
        @(negedge clk); #1;
        chk("lw_end_state", 32'(state), 32'd0);

        // BEQ: zero gates pc_en combinationally
        op = 4'b0011;
        @(negedge clk); #1;
        chk("beq_decode_state", 32'(state), 32'd1);
        @(negedge clk); zero = 1'b1; #1;
        chk("beq_ex_state", 32'(state), 32'd8);
        chk("beq_taken_ctl", 32'({pc_en, pc_src, alu_f, alu_src_a, alu_src_b, retire}),
            32'({1'b1, 2'b01, 3'b110, 1'b1, 2'b00, 1'b1}));
        zero = 1'b0; #1;
        chk("beq_nottaken_pc_en", 32'(pc_en), 32'd0);
        @(negedge clk); #1;
        chk("beq_end_state", 32'(state), 32'd0);

        // SW with mem_ready delayed two cycles: mem_write high three cycles
        op = 4'b0010;
        @(negedge clk); #1;
        chk("sw_decode_state", 32'(state), 32'd1);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("sw_memadr_state", 32'(state), 32'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("sw_wait_state", 32'(state), 32'd5);
            chk("sw_wait_ctl", 32'({mem_write, iord, retire}), 32'b110);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("sw_ready_state", 32'(state), 32'd5);
        chk("sw_ready_ctl", 32'({mem_write, iord, retire}), 32'b111);
        @(negedge clk); #1;
        chk("sw_end_state", 32'(state), 32'd0);
        chk("sw_end_mem_write", 32'(mem_write), 32'd0);

        // ADDI: 0,1,9,10,0
        op = 4'b0100;
        @(negedge clk); #1;
        chk("addi_decode_state", 32'(state), 32'd1);
        @(negedge clk); #1;
        chk("addi_ex_state", 32'(state), 32'd9);
        chk("addi_ex_ctl", 32'({alu_src_a, alu_src_b, alu_f}), 32'({1'b1, 2'b10, 3'b010}));
        @(negedge clk); #1;
        chk("addi_wb_state", 32'(state), 32'd10);
        chk("addi_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg, retire}), 32'b1001);
        @(negedge clk); #1;
        chk("addi_end_state", 32'(state), 32'd0);

        // J: 0,1,11,0
        op = 4'b0101;
        @(negedge clk); #1;
        chk("j_decode_state", 32'(state), 32'd1);
        @(negedge clk); #1;
        chk("j_ex_state", 32'(state), 32'd11);
        chk("j_ex_ctl", 32'({pc_en, pc_src, retire, reg_write}), 32'({1'b1, 2'b10, 1'b1, 1'b0}));
        @(negedge clk); #1;
        chk("j_end_state", 32'(state), 32'd0);

        // R-type funct 011: illegal pulse, no writeback
        op = 4'b0000; funct = 3'b011;
        @(negedge clk); #1;
        chk("f011_decode_state", 32'(state), 32'd1);
        chk("f011_illegal", 32'({illegal, reg_write, retire}), 32'b100);
        chk("f011_trap_illegal", 32'(t_illegal), 32'd1);
        @(negedge clk); op = 4'b1111; funct = 3'b000; #1;
        chk("f011_next_state", 32'(state), 32'd0);
        chk("f011_illegal_gone", 32'(illegal), 32'd0);

        // op 1111 loops FETCH/DECODE on the skip instance; trap instance parked
        for (int i = 0; i < 100; i++) begin
            chk("halt_state", 32'(t_state), 32'd12);
            chk("halt_enables", 32'({t_pc_en, t_ir_write, t_mem_write, t_reg_write,
                t_illegal, t_retire, t_alu_f}), 32'd0);
            chk("op15_state", 32'(state), 32'(i % 2));
            chk("op15_illegal", 32'(illegal), 32'(i % 2));
            @(negedge clk); #1;
        end

        // release the trap instance; reset the skip instance inside MEMWR
        chk("op15_end_state", 32'(state), 32'd0);
        reset_t_n = 1'b0; op = 4'b0010; mem_ready = 1'b1; #1;
        chk("trap_rst_state", 32'(t_state), 32'd0);
        chk("trap_rst_ir_write", 32'(t_ir_write), 32'd0);
        @(negedge clk); reset_t_n = 1'b1; #1;
        chk("rsw_decode_state", 32'(state), 32'd1);
        chk("trap_refetch_state", 32'(t_state), 32'd0);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("rsw_memadr_state", 32'(state), 32'd2);
        chk("trap_decode_state", 32'(t_state), 32'd1);
        @(negedge clk); #1;
        chk("rsw_memwr_state", 32'(state), 32'd5);
        chk("rsw_memwr_mem_write", 32'(mem_write), 32'd1);
        reset_n = 1'b0; #1;
        chk("rsw_rst_state", 32'(state), 32'd0);
        chk("rsw_rst_strobes", 32'({mem_write, retire, reg_write, pc_en, ir_write}), 32'd0);
        @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1; op = 4'b0000; funct = 3'b001; #1;
        chk("rsw_post_state", 32'(state), 32'd0);
        chk("rsw_post_ir_write", 32'(ir_write), 32'd1);
        @(negedge clk); #1;
        chk("rsw_refetch_state", 32'(state), 32'd1);
        @(negedge clk); #1;
        chk("or_rtex_alu_f", 32'({state, alu_f}), 32'({4'd6, 3'b001}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
